// File: rtl/conv33_seq.sv
// conv33_seq: layer sequencer for a 3x3 convolution core.
// Per output channel it streams 9 weights, a bias and a scale, then issues output windows with a bounded in-flight count.
//
// state  | meaning
// IDLE   | waiting for start; nothing in progress
// LOAD_W | accepting the 9 weight beats of the current channel
// LOAD_B | accepting the bias beat
// LOAD_S | accepting the scale beat
// RUN    | issuing window requests in row-major order
// DRAIN  | every window issued, waiting for in-flight results
// DONE   | one-cycle layer-complete pulse
module conv33_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int BIAS_WIDTH = 32,
  parameter int DIM_WIDTH  = 8,
  parameter int CH_WIDTH   = 8,
  parameter int MAX_OUTST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  cfg_out_h,
  input  logic [DIM_WIDTH-1:0]  cfg_out_w,
  input  logic [CH_WIDTH-1:0]   cfg_out_ch,
  input  logic                  param_valid,
  output logic                  param_ready,
  input  logic [BIAS_WIDTH-1:0] param_data,
  output logic                  weight_load_en,
  output logic [DATA_WIDTH-1:0] weight_data,
  output logic                  bias_load_en,
  output logic [BIAS_WIDTH-1:0] bias_data,
  output logic                  scale_load_en,
  output logic [BIAS_WIDTH-1:0] scale_data,
  output logic                  win_req,
  output logic [DIM_WIDTH-1:0]  win_row,
  output logic [DIM_WIDTH-1:0]  win_col,
  input  logic                  win_ack,
  input  logic                  core_out_valid,
  output logic [CH_WIDTH-1:0]   ch_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int OUTST_W = $clog2(MAX_OUTST) + 1;
  localparam logic [OUTST_W-1:0]   OUTST_MAX = OUTST_W'(MAX_OUTST);
  localparam logic [OUTST_W-1:0]   OUTST_ONE = OUTST_W'(1);
  localparam logic [DIM_WIDTH-1:0] DIM_ONE   = DIM_WIDTH'(1);
  localparam logic [CH_WIDTH-1:0]  CH_ONE    = CH_WIDTH'(1);
  // Weight beat down-counter reload: 9 beats means terminal count after 8 decrements.
  localparam logic [3:0]           W_TC_LOAD = 4'd8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_B = 3'd2,
    LOAD_S = 3'd3,
    RUN    = 3'd4,
    DRAIN  = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [DIM_WIDTH-1:0]   cfg_h_q, cfg_h_d;
  logic [DIM_WIDTH-1:0]   cfg_w_q, cfg_w_d;
  logic [CH_WIDTH-1:0]    cfg_ch_q, cfg_ch_d;
  logic [CH_WIDTH-1:0]    ch_idx_q, ch_idx_d;
  logic [3:0]             wcnt_q, wcnt_d;
  logic [DIM_WIDTH-1:0]   win_row_q, win_row_d;
  logic [DIM_WIDTH-1:0]   win_col_q, win_col_d;
  logic [OUTST_W-1:0]     outst_q, outst_d;
  logic                   err_q, err_d;

  logic param_ready_i;
  logic beat;
  logic win_req_i;
  logic accept;
  logic last_col;
  logic last_row;
  logic last_ch;
  logic cfg_ok;

  assign param_ready_i = (state_q == LOAD_W) || (state_q == LOAD_B) || (state_q == LOAD_S);
  assign beat          = param_ready_i & param_valid;
  assign win_req_i     = (state_q == RUN) && (outst_q < OUTST_MAX);
  assign accept        = win_req_i & win_ack;
  assign last_col      = (win_col_q == (cfg_w_q - DIM_ONE));
  assign last_row      = (win_row_q == (cfg_h_q - DIM_ONE));
  assign last_ch       = (ch_idx_q == (cfg_ch_q - CH_ONE));
  assign cfg_ok        = (cfg_out_h != '0) && (cfg_out_w != '0) && (cfg_out_ch != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cfg_h_q   <= '0;
      cfg_w_q   <= '0;
      cfg_ch_q  <= '0;
      ch_idx_q  <= '0;
      wcnt_q    <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
      outst_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_h_q   <= cfg_h_d;
      cfg_w_q   <= cfg_w_d;
      cfg_ch_q  <= cfg_ch_d;
      ch_idx_q  <= ch_idx_d;
      wcnt_q    <= wcnt_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      outst_q   <= outst_d;
      err_q     <= err_d;
    end
  end

  // In-flight window counter; a result with nothing in flight is flagged, not counted.
  always_comb begin
    outst_d = outst_q;
    err_d   = 1'b0;
    if (accept && !core_out_valid) begin
      outst_d = outst_q + OUTST_ONE;
    end else if (!accept && core_out_valid) begin
      if (outst_q == '0) begin
        err_d = 1'b1;
      end else begin
        outst_d = outst_q - OUTST_ONE;
      end
    end
    if ((state_q == IDLE) && start && !cfg_ok) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_h_d   = cfg_h_q;
    cfg_w_d   = cfg_w_q;
    cfg_ch_d  = cfg_ch_q;
    ch_idx_d  = ch_idx_q;
    wcnt_d    = wcnt_q;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    case (state_q)
      IDLE: begin
        if (start && cfg_ok) begin
          cfg_h_d  = cfg_out_h;
          cfg_w_d  = cfg_out_w;
          cfg_ch_d = cfg_out_ch;
          ch_idx_d = '0;
          wcnt_d   = W_TC_LOAD;
          state_d  = LOAD_W;
        end
      end
      LOAD_W: begin
        if (beat) begin
          if (wcnt_q == '0) begin
            state_d = LOAD_B;
          end else begin
            wcnt_d = wcnt_q - 4'd1;
          end
        end
      end
      LOAD_B: begin
        if (beat) begin
          state_d = LOAD_S;
        end
      end
      LOAD_S: begin
        if (beat) begin
          win_row_d = '0;
          win_col_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_col) begin
            win_col_d = '0;
            if (last_row) begin
              win_row_d = '0;
              state_d   = DRAIN;
            end else begin
              win_row_d = win_row_q + DIM_ONE;
            end
          end else begin
            win_col_d = win_col_q + DIM_ONE;
          end
        end
      end
      DRAIN: begin
        if (outst_q == '0) begin
          if (last_ch) begin
            state_d = DONE;
          end else begin
            ch_idx_d = ch_idx_q + CH_ONE;
            wcnt_d   = W_TC_LOAD;
            state_d  = LOAD_W;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs are forced low while rst is held, even before the state register clears.
  assign param_ready    = param_ready_i & ~rst;
  assign weight_load_en = beat & (state_q == LOAD_W) & ~rst;
  assign bias_load_en   = beat & (state_q == LOAD_B) & ~rst;
  assign scale_load_en  = beat & (state_q == LOAD_S) & ~rst;
  assign weight_data    = rst ? '0 : param_data[DATA_WIDTH-1:0];
  assign bias_data      = rst ? '0 : param_data;
  assign scale_data     = rst ? '0 : param_data;
  assign win_req        = win_req_i & ~rst;
  assign win_row        = rst ? '0 : win_row_q;
  assign win_col        = rst ? '0 : win_col_q;
  assign ch_idx         = rst ? '0 : ch_idx_q;
  assign busy           = (state_q != IDLE) & ~rst;
  assign done           = (state_q == DONE) & ~rst;
  assign err            = err_q & ~rst;

endmodule

// File: tb/tb_conv33_seq.sv
// tb_conv33_seq: directed bench for conv33_seq with a window scoreboard and a cycle-level expectation model.
module tb_conv33_seq;
  localparam int DW = 8, BW = 32, DIMW = 8, CHW = 8;

  logic            clk = 1'b0;
  logic            rst, start;
  logic [DIMW-1:0] cfg_out_h, cfg_out_w;
  logic [CHW-1:0]  cfg_out_ch;
  logic            param_valid, param_ready;
  logic [BW-1:0]   param_data;
  logic            weight_load_en, bias_load_en, scale_load_en;
  logic [DW-1:0]   weight_data;
  logic [BW-1:0]   bias_data, scale_data;
  logic            win_req, win_ack, core_out_valid;
  logic [DIMW-1:0] win_row, win_col;
  logic [CHW-1:0]  ch_idx;
  logic            busy, done, err;

  always #5 clk = ~clk;

  conv33_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_out_h(cfg_out_h), .cfg_out_w(cfg_out_w), .cfg_out_ch(cfg_out_ch),
    .param_valid(param_valid), .param_ready(param_ready), .param_data(param_data),
    .weight_load_en(weight_load_en), .weight_data(weight_data),
    .bias_load_en(bias_load_en), .bias_data(bias_data),
    .scale_load_en(scale_load_en), .scale_data(scale_data),
    .win_req(win_req), .win_row(win_row), .win_col(win_col), .win_ack(win_ack),
    .core_out_valid(core_out_valid), .ch_idx(ch_idx),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    int row;
    int col;
    int ch;
  } win_t;

  win_t exp_win[$];
  int   total = 0, bad = 0;
  int   acc_cnt = 0, done_cnt = 0, err_cnt = 0, wl_cnt = 0, bl_cnt = 0, sl_cnt = 0;
  bit   acc;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_layer(input int h, input int w, input int c);
    win_t e;
    for (int k = 0; k < c; k++)
      for (int r = 0; r < h; r++)
        for (int q = 0; q < w; q++) begin
          e.row = r; e.col = q; e.ch = k;
          exp_win.push_back(e);
        end
  endtask

  // Sample outputs mid-cycle; accepted windows are popped and compared against the scoreboard.
  task automatic observe();
    win_t e;
    #1;
    acc = win_req && win_ack;
    if (acc) begin
      acc_cnt++;
      if (exp_win.size() == 0) chk("win_unexpected", 1, 0);
      else begin
        e = exp_win.pop_front();
        chk("win_row", int'(win_row), e.row);
        chk("win_col", int'(win_col), e.col);
        chk("win_ch", int'(ch_idx), e.ch);
      end
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (weight_load_en) wl_cnt++;
    if (bias_load_en) bl_cnt++;
    if (scale_load_en) sl_cnt++;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    observe();
    advance();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_win_req"}, int'(win_req), 0);
    chk({tag, "_ready"}, int'(param_ready), 0);
    chk({tag, "_strobes"}, int'({weight_load_en, bias_load_en, scale_load_en}), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // Full layer with win_ack held high and each result returned 2 cycles after its window.
  task automatic run_layer(input int h, input int w, input int c, input bit gapped);
    int beats, ch, results, ch_end, acc_ch, fin, n;
    bit loading, exp_ready, exp_busy, exp_done, exp_beat, exp_wreq, finished;
    int pend[$];
    push_layer(h, w, c);
    beats = 0; ch = 0; results = 0; ch_end = -1; acc_ch = 0; fin = -1;
    loading = 1'b1; finished = 1'b0;
    done_cnt = 0; err_cnt = 0; wl_cnt = 0; bl_cnt = 0; sl_cnt = 0;
    for (n = 0; n < 4000 && !finished; n++) begin
      start          = (n == 0);
      cfg_out_h      = DIMW'(h);
      cfg_out_w      = DIMW'(w);
      cfg_out_ch     = CHW'(c);
      param_valid    = gapped ? (n % 2 == 1) : 1'b1;
      param_data     = $urandom;
      win_ack        = 1'b1;
      core_out_valid = (pend.size() > 0 && pend[0] == n);
      if (core_out_valid) void'(pend.pop_front());
      exp_done = 1'b0;
      if (ch_end >= 0 && n == ch_end + 2) begin
        if (ch == c - 1) begin
          exp_done = 1'b1;
          fin = n;
        end else begin
          ch++; loading = 1'b1; beats = 0; results = 0; acc_ch = 0; ch_end = -1;
        end
      end
      exp_busy  = (n >= 1) && (fin < 0 || n <= fin);
      exp_ready = (n >= 1) && loading;
      exp_beat  = exp_ready && param_valid;
      exp_wreq  = (n >= 1) && !loading && (acc_ch < h * w);
      observe();
      chk("busy", int'(busy), int'(exp_busy));
      chk("param_ready", int'(param_ready), int'(exp_ready));
      chk("done", int'(done), int'(exp_done));
      chk("err", int'(err), 0);
      chk("win_req", int'(win_req), int'(exp_wreq));
      if (n >= 1) chk("ch_idx", int'(ch_idx), ch);
      chk("weight_load_en", int'(weight_load_en), int'(exp_beat && beats < 9));
      chk("bias_load_en", int'(bias_load_en), int'(exp_beat && beats == 9));
      chk("scale_load_en", int'(scale_load_en), int'(exp_beat && beats == 10));
      if (exp_beat && beats < 9) chk("weight_data", int'(weight_data), int'(param_data[DW-1:0]));
      if (exp_beat && beats == 9) chk("bias_data", int'(bias_data), int'(param_data));
      if (exp_beat && beats == 10) chk("scale_data", int'(scale_data), int'(param_data));
      if (exp_beat) begin
        beats++;
        if (beats == 11) loading = 1'b0;
      end
      if (acc) begin
        acc_ch++;
        pend.push_back(n + 2);
      end
      if (core_out_valid) begin
        results++;
        if (results == h * w) ch_end = n;
      end
      if (fin >= 0 && n == fin + 1) finished = 1'b1;
      advance();
    end
    start = 1'b0; param_valid = 1'b0; win_ack = 1'b0; core_out_valid = 1'b0;
    chk("layer_timeout", int'(finished), 1);
    chk("done_count", done_cnt, 1);
    chk("weight_total", wl_cnt, 9 * c);
    chk("bias_total", bl_cnt, c);
    chk("scale_total", sl_cnt, c);
    chk("windows_left", exp_win.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    rst = 1'b1; start = 1'b0; cfg_out_h = '0; cfg_out_w = '0; cfg_out_ch = '0;
    param_valid = 1'b0; param_data = '0; win_ack = 1'b0; core_out_valid = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    observe();
    chk_quiet("rst_hold");
    chk("rst_hold_err", int'(err), 0);
    advance();
    advance();
    rst = 1'b0;
    observe();
    chk_quiet("post_rst");
    chk("post_rst_err", int'(err), 0);
    chk("post_rst_ch_idx", int'(ch_idx), 0);
    chk("post_rst_win_row", int'(win_row), 0);
    chk("post_rst_win_col", int'(win_col), 0);
    advance();

    // Basic layer, gapped parameters, multi-channel
    run_layer(2, 3, 1, 1'b0);
    run_layer(2, 2, 1, 1'b1);
    run_layer(2, 2, 2, 1'b0);
    run_layer(1, 1, 3, 1'b1);

    // Backpressure: results withheld
    push_layer(2, 3, 1);
    done_cnt = 0; err_cnt = 0;
    start = 1'b1; cfg_out_h = 8'd2; cfg_out_w = 8'd3; cfg_out_ch = 8'd1;
    cyc();
    start = 1'b0; param_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      param_data = $urandom;
      cyc();
    end
    param_valid = 1'b0; win_ack = 1'b1; acc_cnt = 0;
    for (int i = 0; i < 8; i++) cyc();
    chk("bp_accepts", acc_cnt, 4);
    start = 1'b1; cfg_out_w = 8'd0;
    observe();
    chk("bp_req_low", int'(win_req), 0);
    advance();
    start = 1'b0;
    observe();
    chk("bp_start_ignored_err", int'(err), 0);
    chk("bp_start_ignored_busy", int'(busy), 1);
    advance();
    core_out_valid = 1'b1; acc_cnt = 0;
    cyc();
    core_out_valid = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("bp_one_more", acc_cnt, 1);
    sent = 1;
    for (int i = 0; i < 20; i++) begin
      core_out_valid = (sent < 6);
      if (core_out_valid) sent++;
      cyc();
    end
    core_out_valid = 1'b0; win_ack = 1'b0;
    observe();
    chk("bp_done_count", done_cnt, 1);
    chk("bp_err_count", err_cnt, 0);
    chk("bp_busy_end", int'(busy), 0);
    chk("bp_windows_left", exp_win.size(), 0);
    advance();

    // Bad configurations: w=0, h=0, ch=0
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      cfg_out_h  = (i == 1) ? 8'd0 : 8'd2;
      cfg_out_w  = (i == 0) ? 8'd0 : 8'd2;
      cfg_out_ch = (i == 2) ? 8'd0 : 8'd1;
      cyc();
      start = 1'b0;
      observe();
      chk("badcfg_err", int'(err), 1);
      chk("badcfg_busy", int'(busy), 0);
      advance();
      observe();
      chk("badcfg_err_clear", int'(err), 0);
      chk("badcfg_busy_after", int'(busy), 0);
      advance();
    end

    // Reset in RUN after 3 accepts
    push_layer(2, 3, 1);
    start = 1'b1; cfg_out_h = 8'd2; cfg_out_w = 8'd3; cfg_out_ch = 8'd1;
    cyc();
    start = 1'b0; param_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      param_data = $urandom;
      cyc();
    end
    win_ack = 1'b1; acc_cnt = 0;
    for (int i = 0; i < 3; i++) cyc();
    chk("rst_run_accepts", acc_cnt, 3);
    rst = 1'b1;
    observe();
    chk_quiet("rst_run_during");
    advance();
    rst = 1'b0;
    observe();
    chk_quiet("rst_run_after");
    chk("rst_run_err", int'(err), 0);
    chk("rst_run_win_row", int'(win_row), 0);
    chk("rst_run_win_col", int'(win_col), 0);
    advance();
    exp_win.delete();
    param_valid = 1'b0; win_ack = 1'b0;

    // Spurious result in IDLE
    core_out_valid = 1'b1;
    cyc();
    core_out_valid = 1'b0;
    observe();
    chk("spurious_err", int'(err), 1);
    chk("spurious_busy", int'(busy), 0);
    advance();
    observe();
    chk("spurious_err_clear", int'(err), 0);
    chk("spurious_busy_after", int'(busy), 0);
    advance();

    run_layer(2, 3, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
